// File: rtl/nbit_bit_scatter.sv
// -----------------------------------------------------------------------------
// nbit_bit_scatter
//
// Sequential bit-scatter unit. An accepted N-bit word is held in the
// remaining-bits register and its set bits are emitted one per beat, lowest
// index first. Each beat carries the bit index and its one-hot mask; OR-ing
// all masks of a word reconstructs the word. An all-zero word produces a
// single beat with mask 0, index 0 and last set.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous, active-low reset
//   in_valid   upstream word valid
//   in_ready   unit can accept a word (combinational only from out_ready/rst_n)
//   in_val     word to scatter, sampled only on the accept edge
//   out_valid  beat valid
//   out_ready  downstream accepts beat
//   out_idx    index of emitted set bit (zero-extended into W bits)
//   out_mask   one-hot mask of emitted bit (zero for an empty word)
//   out_last   final beat of the current word
//   busy       a word is in progress
// -----------------------------------------------------------------------------
module nbit_bit_scatter #(
    parameter  int N = 32,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_val,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_mask,
    output logic         out_last,
    output logic         busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    localparam logic [N-1:0] ZERO_N = {N{1'b0}};
    localparam logic [N-1:0] ONE_N  = {{(N-1){1'b0}}, 1'b1};

    state_t         state_q;
    state_t         state_d;
    logic [N-1:0]   rem_q;
    logic [N-1:0]   rem_d;

    logic [N-1:0]   low_mask_s;
    logic [N-1:0]   rest_s;
    logic           emit_s;
    logic           last_s;
    logic           fire_s;

    // Index of the single set bit of a one-hot (or all-zero) vector.
    function automatic logic [W-1:0] onehot_to_idx(input logic [N-1:0] oh);
        logic [W-1:0] idx;
        idx = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (oh[i]) begin
                idx = idx | W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Beat outputs: derived only from the held word and the state.
    always_comb begin
        // Two's-complement trick isolates the lowest set bit (modulo 2^N).
        low_mask_s = rem_q & (~rem_q + ONE_N);
        // rem with its lowest set bit cleared; zero means this is the last bit.
        rest_s     = rem_q & (rem_q - ONE_N);
        emit_s     = (state_q == ST_EMIT);
        last_s     = (rest_s == ZERO_N);
        fire_s     = emit_s && out_ready;

        out_valid  = emit_s;
        busy       = emit_s;
        if (emit_s) begin
            out_mask = low_mask_s;
            out_idx  = onehot_to_idx(low_mask_s);
            out_last = last_s;
        end else begin
            out_mask = ZERO_N;
            out_idx  = {W{1'b0}};
            out_last = 1'b0;
        end

        // A new word may be taken while idle or in the cycle the last beat leaves.
        in_ready = rst_n && (!emit_s || (fire_s && last_s));
    end

    // Next-state and remaining-bits update.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    rem_d   = in_val;
                    state_d = ST_EMIT;
                end else begin
                    rem_d   = rem_q;
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (fire_s && !last_s) begin
                    rem_d   = rem_q & ~low_mask_s;
                    state_d = ST_EMIT;
                end else if (fire_s && in_valid) begin
                    // Back-to-back: next word loads in the last-beat cycle.
                    rem_d   = in_val;
                    state_d = ST_EMIT;
                end else if (fire_s) begin
                    rem_d   = ZERO_N;
                    state_d = ST_IDLE;
                end else begin
                    rem_d   = rem_q;
                    state_d = ST_EMIT;
                end
            end
            default: begin
                rem_d   = ZERO_N;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and held-word registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= ZERO_N;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

endmodule
